result_collector: RTL and testbench

- Sits directly downstream of the 4x4 systolic array's output datapath.
- Drives the array's src_ready and captures the eight 64-bit result beats, each carrying two signed 32-bit C elements.
- Narrows each element to OUT_W bits, with optional saturation, and stores all 16 in a register file.
- Exposes the finished C matrix through a registered random-access read port until the consumer releases it.

---
 rtl/result_collector.sv | 155 +++++++++++++++
 tb/tb_result_collector.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// result_collector
// Captures the eight 64-bit result beats of the 4x4 systolic array, narrows each
// signed element to OUT_W bits (saturating when SAT_EN is set) and serves the
// finished C matrix through a registered read port until the consumer frees it.
// `release` is a reserved word in SystemVerilog, so the consumer's release pulse
// is the port buf_release.
module result_collector #(
    parameter int BEATS  = 8,
    parameter int ACC_W  = 32,
    parameter int OUT_W  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [2*ACC_W-1:0]         in_data,
    output logic                       in_ready,
    input  logic                       mult_done,
    input  logic                       buf_release,
    input  logic                       rd_en,
    input  logic [$clog2(2*BEATS)-1:0] rd_addr,
    output logic signed [OUT_W-1:0]    rd_data,
    output logic                       rd_valid,
    output logic                       result_ready,
    output logic [2*BEATS-1:0]         sat_flags,
    output logic                       err_short
);

    localparam int ELEMS = 2 * BEATS;
    localparam int IW    = $clog2(ELEMS);
    localparam int CW    = $clog2(BEATS);

    // Narrowing limits, expressed at accumulator width for signed comparison.
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WAIT_DONE,
        HOLD
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           cnt;
    logic                    done_seen;
    logic [OUT_W-1:0]        elems [ELEMS];

    logic                    accept;
    logic                    last_beat;
    logic signed [ACC_W-1:0] elem_hi;
    logic signed [ACC_W-1:0] elem_lo;
    logic [OUT_W:0]          nar_hi;
    logic [OUT_W:0]          nar_lo;
    logic [IW-1:0]           idx_hi;
    logic [IW-1:0]           idx_lo;

    // Returns {saturated, narrowed value}.
    function automatic logic [OUT_W:0] narrow(input logic signed [ACC_W-1:0] v);
        logic [OUT_W:0] r;
        r = {1'b0, v[OUT_W-1:0]};
        if (SAT_EN) begin
            if (v > MAX_V)      r = {1'b1, MAX_V[OUT_W-1:0]};
            else if (v < MIN_V) r = {1'b1, MIN_V[OUT_W-1:0]};
        end
        return r;
    endfunction

    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == CW'(BEATS - 1));
    assign elem_hi   = in_data[2*ACC_W-1:ACC_W];
    assign elem_lo   = in_data[ACC_W-1:0];
    assign nar_hi    = narrow(elem_hi);
    assign nar_lo    = narrow(elem_lo);
    assign idx_hi    = {cnt, 1'b0};
    assign idx_lo    = {cnt, 1'b1};

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; a final beat always goes through WAIT_DONE, even with mult_done.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = COLLECT;
            COLLECT: begin
                if (accept && last_beat) state_nxt = WAIT_DONE;
                else if (mult_done)      state_nxt = HOLD;
            end
            WAIT_DONE: if (mult_done || done_seen) state_nxt = HOLD;
            HOLD:      if (buf_release) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the state.
    // NOTE: defaults before the case keep this block free of inferred latches.
    always_comb begin
        in_ready     = 1'b0;
        result_ready = 1'b0;
        case (state)
            IDLE, COLLECT: in_ready     = 1'b1;
            HOLD:          result_ready = 1'b1;
            default:       ;
        endcase
    end

    // Beat capture, beat counter, saturation flags and error bookkeeping.
    // NOTE: the element file is reset so a short transfer straight after reset reads zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            done_seen <= 1'b0;
            err_short <= 1'b0;
            sat_flags <= '0;
            for (int i = 0; i < ELEMS; i++) elems[i] <= '0;
        end else begin
            if (accept) begin
                elems[idx_hi]     <= nar_hi[OUT_W-1:0];
                elems[idx_lo]     <= nar_lo[OUT_W-1:0];
                sat_flags[idx_hi] <= sat_flags[idx_hi] | nar_hi[OUT_W];
                sat_flags[idx_lo] <= sat_flags[idx_lo] | nar_lo[OUT_W];
                cnt               <= cnt + 1'b1;
            end
            // Remember a mult_done that arrived together with the final beat.
            if (state == COLLECT && accept && last_beat) done_seen <= mult_done;
            if (state == COLLECT && mult_done && !(accept && last_beat)) err_short <= 1'b1;
            if (state == HOLD && buf_release) begin
                cnt       <= '0;
                done_seen <= 1'b0;
                err_short <= 1'b0;
                sat_flags <= '0;
            end
        end
    end

    // Registered read port, active only while the matrix is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if (rd_en && state == HOLD) begin
            rd_data  <= elems[rd_addr];
            rd_valid <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector
// Two collectors (saturating and wrapping) share one stimulus stream. A
// count-based matrix model predicts status outputs each cycle; predicted reads
// go into a scoreboard queue that a negedge monitor drains on rd_valid.
module tb_result_collector;

    localparam int BEATS = 8;
    localparam int ELEMS = 16;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        mult_done;
    logic        buf_release;
    logic        rd_en;
    logic [3:0]  rd_addr;

    logic        s_in_ready, s_rd_valid, s_result_ready, s_err_short;
    logic [15:0] s_rd_data, s_sat_flags;
    logic        w_in_ready, w_rd_valid, w_result_ready, w_err_short;
    logic [15:0] w_rd_data, w_sat_flags;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model of the held matrix
    logic [15:0] m_sat  [ELEMS];
    logic [15:0] m_wrap [ELEMS];
    logic [15:0] m_flags;
    int          m_beats;
    bit          m_ready;
    bit          m_pend;
    bit          m_err;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] s;
        logic [15:0] w;
        int          due;
    } rd_exp_t;

    rd_exp_t sb[$];
    rd_exp_t mon_e;

    result_collector #(.BEATS(8), .ACC_W(32), .OUT_W(16), .SAT_EN(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(s_in_ready), .mult_done(mult_done), .buf_release(buf_release),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(s_rd_data), .rd_valid(s_rd_valid),
        .result_ready(s_result_ready), .sat_flags(s_sat_flags), .err_short(s_err_short)
    );

    result_collector #(.BEATS(8), .ACC_W(32), .OUT_W(16), .SAT_EN(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(w_in_ready), .mult_done(mult_done), .buf_release(buf_release),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(w_rd_data), .rd_valid(w_rd_valid),
        .result_ready(w_result_ready), .sat_flags(w_sat_flags), .err_short(w_err_short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sat16(input int v);
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return v[15:0];
    endfunction

    function automatic bit over16(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    function automatic logic [63:0] beat(input int hi, input int lo);
        return {hi, lo};
    endfunction

    function automatic int rnd_elem();
        int r;
        case ($urandom_range(0, 3))
            0: r = int'($urandom);
            1: r = int'($urandom_range(0, 65535)) - 32768;
            2: r = int'($urandom_range(0, 80000)) - 40000;
            default: begin
                case ($urandom_range(0, 3))
                    0:       r = 32767;
                    1:       r = 32768;
                    2:       r = -32768;
                    default: r = -32769;
                endcase
            end
        endcase
        return r;
    endfunction

    function automatic logic [63:0] rnd_beat();
        return beat(rnd_elem(), rnd_elem());
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ELEMS; i++) begin
            m_sat[i]  = '0;
            m_wrap[i] = '0;
        end
        m_flags = '0;
        m_beats = 0;
        m_ready = 1'b0;
        m_pend  = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_write(input int k, input logic [63:0] d);
        int hi;
        int lo;
        hi = d[63:32];
        lo = d[31:0];
        m_sat[2*k]    = sat16(hi);
        m_sat[2*k+1]  = sat16(lo);
        m_wrap[2*k]   = hi[15:0];
        m_wrap[2*k+1] = lo[15:0];
        if (over16(hi)) m_flags[2*k]   = 1'b1;
        if (over16(lo)) m_flags[2*k+1] = 1'b1;
        m_beats = k + 1;
    endtask

    task automatic check_status();
        bit exp_rdy;
        exp_rdy = (m_beats < BEATS) && !m_ready;
        check("in_ready_sat",      s_in_ready,     exp_rdy);
        check("in_ready_wrap",     w_in_ready,     exp_rdy);
        check("result_ready_sat",  s_result_ready, m_ready);
        check("result_ready_wrap", w_result_ready, m_ready);
        check("err_short_sat",     s_err_short,    m_err);
        check("err_short_wrap",    w_err_short,    m_err);
        check("sat_flags_sat",     s_sat_flags,    m_flags);
        check("sat_flags_wrap",    w_sat_flags,    16'h0000);
    endtask

    // One clock cycle: drive inputs, advance the model from its pre-edge view, check status.
    task automatic step(input bit v, input logic [63:0] d, input bit md, input bit rel,
                        input bit re, input logic [3:0] a);
        int pre_beats;
        bit pre_ready;
        bit pre_pend;
        bit acc;
        in_valid    = v;
        in_data     = d;
        mult_done   = md;
        buf_release = rel;
        rd_en       = re;
        rd_addr     = a;
        pre_beats = m_beats;
        pre_ready = m_ready;
        pre_pend  = m_pend;
        acc = v && (pre_beats < BEATS) && !pre_ready;
        if (re && pre_ready) sb.push_back('{addr: a, s: m_sat[a], w: m_wrap[a], due: cyc + 1});
        if (acc) model_write(pre_beats, d);
        if (pre_pend) begin
            m_ready = 1'b1;
            m_pend  = 1'b0;
        end else if (md && !pre_ready && pre_beats > 0) begin
            if (pre_beats == BEATS) begin
                m_ready = 1'b1;
            end else if (acc && pre_beats == BEATS - 1) begin
                m_pend = 1'b1;
            end else begin
                m_err   = 1'b1;
                m_ready = 1'b1;
            end
        end
        if (rel && pre_ready) begin
            m_ready = 1'b0;
            m_beats = 0;
            m_err   = 1'b0;
            m_flags = '0;
        end
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic idle();
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    // Asserts reset between clock edges and checks reset values immediately.
    task automatic async_reset();
        in_valid    = 1'b0;
        in_data     = '0;
        mult_done   = 1'b0;
        buf_release = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        #3;
        reset = 1'b0;
        #1;
        model_clear();
        check("rst_in_ready_sat",     s_in_ready,     1'b1);
        check("rst_in_ready_wrap",    w_in_ready,     1'b1);
        check("rst_rd_valid_sat",     s_rd_valid,     1'b0);
        check("rst_rd_valid_wrap",    w_rd_valid,     1'b0);
        check("rst_rd_data_sat",      s_rd_data,      16'h0000);
        check("rst_rd_data_wrap",     w_rd_data,      16'h0000);
        check("rst_result_ready_sat", s_result_ready, 1'b0);
        check("rst_sat_flags_sat",    s_sat_flags,    16'h0000);
        check("rst_err_short_sat",    s_err_short,    1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (s_rd_valid || w_rd_valid) begin
            if (sb.size() == 0) begin
                check("rd_valid_unexpected", 64'(s_rd_valid | w_rd_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rd_latency", 64'(cyc), 64'(mon_e.due));
                check("rd_valid_sat", s_rd_valid, 1'b1);
                check("rd_valid_wrap", w_rd_valid, 1'b1);
                check($sformatf("rd_data_sat[%0d]", mon_e.addr), s_rd_data, mon_e.s);
                check($sformatf("rd_data_wrap[%0d]", mon_e.addr), w_rd_data, mon_e.w);
            end
        end
    end

    initial begin
        reset = 1'b0;
        model_clear();
        async_reset();

        // Identity-scaled matrix; a stray mult_done in IDLE is ignored
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < BEATS; k++) step(1'b1, beat(2 * k, 2 * k + 1), 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int a = 0; a < ELEMS; a++) step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 4'(a));
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 4'd3);
        idle();

        // Saturation in both directions on beat 0
        step(1'b1, beat(40000, -40000), 1'b0, 1'b0, 1'b0, 4'd0);
        for (int k = 1; k < BEATS; k++) step(1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 4'd1);
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        idle();

        // Stalled source, then extra beats offered while in_ready is low
        for (int i = 0; i < 2 * BEATS; i++) step((i % 2) == 0, rnd_beat(), 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, rnd_beat(), 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, rnd_beat(), 1'b1, 1'b0, 1'b0, 4'd0);
        step(1'b1, rnd_beat(), 1'b0, 1'b0, 1'b0, 4'd0);
        for (int a = 0; a < ELEMS; a++) step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 4'(a));
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Short transfer: elements 10..15 keep the previous matrix
        for (int k = 0; k < 5; k++) step(1'b1, rnd_beat(), 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int a = 0; a < ELEMS; a++) step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 4'(a));
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 4'd0);
        idle();

        // Boundary values, final beat coincident with mult_done, read + release together
        for (int k = 0; k < 6; k++) step(1'b1, rnd_beat(), 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, beat(-32768, -32769), 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b1, beat(32767, 32768), 1'b1, 1'b0, 1'b0, 4'd0);
        idle();
        for (int a = 12; a < ELEMS; a++) step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 4'(a));
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 4'd5);
        idle();

        // Async reset mid-COLLECT, then a fresh transfer
        for (int k = 0; k < 3; k++) step(1'b1, rnd_beat(), 1'b0, 1'b0, 1'b0, 4'd0);
        async_reset();
        for (int k = 0; k < BEATS; k++) step(1'b1, rnd_beat(), 1'b0, 1'b0, 1'b0, 4'd0);
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, 4'($urandom_range(0, 15)));
        step(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Randomised matrices: random valid gaps, occasional early mult_done, stray reads
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 60 && !m_ready; i++)
                step($urandom_range(0, 9) < 7, rnd_beat(),
                     (m_beats == BEATS) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0),
                     1'b0, $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
            for (int i = 0; i < 12; i++)
                step($urandom_range(0, 1) == 1, rnd_beat(), 1'b0, 1'b0,
                     $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
            step(1'b0, 64'd0, 1'b0, 1'b1, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
            idle();
        end

        idle();
        idle();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
